// File: rtl/turbo_frame_receiver.sv
// Serial turbo-encoded frame receiver: captures systematic and tail bits, re-encodes the
// systematic stream with the constituent RSC encoder and counts parity-1 mismatches.
module turbo_frame_receiver #(
  parameter int unsigned K     = 1148,
  parameter int unsigned ERR_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_TE_data,
  output logic             busy,
  output logic             frame_done,
  output logic [K-1:0]     MSD_CRC,
  output logic [2:0]       TAIL_1,
  output logic [2:0]       PTAIL_1,
  output logic [ERR_W-1:0] err_cnt,
  output logic             frame_ok
);

  localparam int unsigned N  = 3 * K + 12;
  localparam int unsigned CW = $clog2(N);
  localparam int unsigned KW = $clog2(K);

  localparam logic [CW-1:0] JSysEnd   = CW'(K - 1);
  localparam logic [CW-1:0] JTailEnd  = CW'(K + 5);
  localparam logic [CW-1:0] JTail1End = CW'(K + 2);
  localparam logic [CW-1:0] JPar1End  = CW'(2 * K + 5);
  localparam logic [CW-1:0] JPtailEnd = CW'(2 * K + 8);
  localparam logic [CW-1:0] JLast     = CW'(N - 1);
  localparam logic [CW-1:0] P1Base    = CW'(K + 6);

  typedef enum logic [2:0] {StIdle, StSys, StTail, StPar1, StPtail1, StSkip, StDone} state_e;

  state_e          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      rsc;      // {s2, s1, s0}
  logic [K-1:0]    exp_par;
  logic [KW-1:0]   k_idx;
  logic [KW-1:0]   p_idx;
  logic            exp_bit;

  assign k_idx   = cnt[KW-1:0];
  assign p_idx   = KW'(cnt - P1Base);
  assign exp_bit = rsc[2] ^ rsc[1] ^ rsc[0] ^ in_TE_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      cnt        <= '0;
      rsc        <= '0;
      exp_par    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      err_cnt    <= '0;
      MSD_CRC    <= '0;
      TAIL_1     <= '0;
      PTAIL_1    <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          frame_done <= 1'b0;
          if (start) begin
            state    <= StSys;
            cnt      <= '0;
            rsc      <= '0;
            err_cnt  <= '0;
            frame_ok <= 1'b0;
            busy     <= 1'b1;
          end
        end
        StSys: begin
          MSD_CRC[k_idx] <= in_TE_data;
          exp_par[k_idx] <= exp_bit;
          rsc            <= {rsc[1], rsc[0], rsc[2] ^ rsc[1] ^ in_TE_data};
          cnt            <= cnt + 1'b1;
          if (cnt == JSysEnd) state <= StTail;
        end
        StTail: begin
          // Only tail1 is kept; tail2 is consumed and dropped.
          if (cnt <= JTail1End) TAIL_1 <= {TAIL_1[1:0], in_TE_data};
          cnt <= cnt + 1'b1;
          if (cnt == JTailEnd) state <= StPar1;
        end
        StPar1: begin
          if ((in_TE_data != exp_par[p_idx]) && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
          cnt <= cnt + 1'b1;
          if (cnt == JPar1End) state <= StPtail1;
        end
        StPtail1: begin
          PTAIL_1 <= {PTAIL_1[1:0], in_TE_data};
          cnt     <= cnt + 1'b1;
          if (cnt == JPtailEnd) state <= StSkip;
        end
        StSkip: begin
          cnt <= cnt + 1'b1;
          if (cnt == JLast) begin
            state      <= StDone;
            frame_done <= 1'b1;
            frame_ok   <= (err_cnt == '0);
          end
        end
        StDone: begin
          // start is deliberately ignored here.
          state      <= StIdle;
          frame_done <= 1'b0;
          busy       <= 1'b0;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
